pc_redirect_ctrl: RTL and testbench

- Sequencing controller for the fetch PC-select mux (pc+4 / branch target / mtvec / mepc).
- Arbitrates redirect sources (EX branch resolution, trap, mret) and drives pc_sel and PC write enable.
- Holds a pending redirect while instruction memory stalls, runs the trap-entry flush sequence, and writes mepc/mcause.
- Sits between EX/commit logic and IF_block; its pc_sel and held target feed the PC mux select and D1 inputs.

---
 rtl/pc_redirect_ctrl_pkg.sv | 21 ++
 rtl/pc_redirect_ctrl_hold_reg.sv | 44 ++++
 rtl/pc_redirect_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_ctrl_pkg.sv
// rtl/pc_redirect_ctrl_pkg.sv - shared constants and types for the PC redirect controller
// Contents:
//   PC_SEL_*          encodings for the fetch PC mux select
//   redirect_state_e  controller state
//   DEFAULT_CAUSE_W   default mcause width
package pc_redirect_ctrl_pkg;

  localparam logic [1:0] PC_SEL_SEQ  = 2'd0;  // pc+4
  localparam logic [1:0] PC_SEL_BR   = 2'd1;  // branch target (mux D1)
  localparam logic [1:0] PC_SEL_TRAP = 2'd2;  // mtvec
  localparam logic [1:0] PC_SEL_MRET = 2'd3;  // mepc

  localparam int DEFAULT_CAUSE_W = 32;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } redirect_state_e;

endpackage

// File: rtl/pc_redirect_ctrl_hold_reg.sv
// rtl/pc_redirect_ctrl_hold_reg.sv - holding register for a pending redirect target and select
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   load_i           capture sel_d_i into the held select
//   load_tgt_i       capture tgt_d_i into the held target (only branches need it)
//   clear_i          discard the pending redirect (select back to pc+4, target 0)
//   sel_d_i, tgt_d_i next select / target
//   sel_q_o, tgt_q_o held select / target
module redirect_hold_reg
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             load_tgt_i,
  input  logic             clear_i,
  input  logic [1:0]       sel_d_i,
  input  logic [WIDTH-1:0] tgt_d_i,
  output logic [1:0]       sel_q_o,
  output logic [WIDTH-1:0] tgt_q_o
);

  logic [1:0]       sel_q;
  logic [WIDTH-1:0] tgt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= PC_SEL_SEQ;
      tgt_q <= '0;
    end else if (clear_i) begin
      sel_q <= PC_SEL_SEQ;
      tgt_q <= '0;
    end else begin
      if (load_i)     sel_q <= sel_d_i;
      if (load_tgt_i) tgt_q <= tgt_d_i;
    end
  end

  assign sel_q_o = sel_q;
  assign tgt_q_o = tgt_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - fetch PC-select sequencer: branch/mret/trap redirect arbitration
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   br_taken_ex, br_target_ex        EX taken branch and its target
//   mret_ex                          mret resolved in EX
//   trap_req, trap_pc, trap_cause    level trap request (held until trap_ack) and its context
//   imem_ready                       instruction memory accepts a PC this cycle
//   pc_sel, target_out, pc_we        PC mux select, mux D1 target, PC load enable
//   flush_if, flush_id               pipeline register flushes
//   mepc_we/wdata, mcause_we/wdata   CSR write port for trap entry
//   trap_ack                         one-cycle trap acceptance pulse
//   busy                             controller is not in RUN
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int CAUSE_W = DEFAULT_CAUSE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               br_taken_ex,
  input  logic [WIDTH-1:0]   br_target_ex,
  input  logic               mret_ex,
  input  logic               trap_req,
  input  logic [WIDTH-1:0]   trap_pc,
  input  logic [CAUSE_W-1:0] trap_cause,
  input  logic               imem_ready,
  output logic [1:0]         pc_sel,
  output logic [WIDTH-1:0]   target_out,
  output logic               pc_we,
  output logic               flush_if,
  output logic               flush_id,
  output logic               mepc_we,
  output logic [WIDTH-1:0]   mepc_wdata,
  output logic               mcause_we,
  output logic [CAUSE_W-1:0] mcause_wdata,
  output logic               trap_ack,
  output logic               busy
);

  redirect_state_e    state_q, state_d;
  logic [WIDTH-1:0]   trap_pc_q;
  logic [CAUSE_W-1:0] trap_cause_q;
  logic               trap_latch;

  logic               hold_load, hold_load_tgt, hold_clear;
  logic [1:0]         hold_sel_d;
  logic [1:0]         sel_q;
  logic [WIDTH-1:0]   tgt_q;

  redirect_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (hold_load),
    .load_tgt_i (hold_load_tgt),
    .clear_i    (hold_clear),
    .sel_d_i    (hold_sel_d),
    .tgt_d_i    (br_target_ex),
    .sel_q_o    (sel_q),
    .tgt_q_o    (tgt_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      trap_pc_q    <= '0;
      trap_cause_q <= '0;
    end else begin
      state_q <= state_d;
      if (trap_latch) begin
        trap_pc_q    <= trap_pc;
        trap_cause_q <= trap_cause;
      end
    end
  end

  // Next state, hold-register control and outputs. The RUN-state branch/mret
  // path and the pc_we=imem_ready handshake depend on live inputs so the PC
  // can be redirected in the same cycle EX resolves.
  always_comb begin
    state_d       = state_q;
    trap_latch    = 1'b0;
    hold_load     = 1'b0;
    hold_load_tgt = 1'b0;
    hold_clear    = 1'b0;
    hold_sel_d    = PC_SEL_SEQ;

    pc_sel     = PC_SEL_SEQ;
    target_out = br_target_ex;
    pc_we      = 1'b0;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    mepc_we    = 1'b0;
    mcause_we  = 1'b0;
    trap_ack   = 1'b0;
    busy       = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (trap_req) begin
          // Accept the trap; any same-cycle branch/mret is dropped.
          trap_ack   = 1'b1;
          trap_latch = 1'b1;
          state_d    = ST_FLUSH;
        end else if (mret_ex || br_taken_ex) begin
          pc_sel   = mret_ex ? PC_SEL_MRET : PC_SEL_BR;
          flush_if = 1'b1;
          flush_id = 1'b1;
          pc_we    = imem_ready;
          if (!imem_ready) begin
            hold_load     = 1'b1;
            hold_load_tgt = !mret_ex;
            hold_sel_d    = mret_ex ? PC_SEL_MRET : PC_SEL_BR;
            state_d       = ST_REDIRECT;
          end
        end else begin
          pc_we = imem_ready;
        end
      end

      ST_FLUSH: begin
        busy       = 1'b1;
        target_out = tgt_q;
        flush_if   = 1'b1;
        flush_id   = 1'b1;
        mepc_we    = 1'b1;
        mcause_we  = 1'b1;
        hold_load  = 1'b1;
        hold_sel_d = PC_SEL_TRAP;
        state_d    = ST_REDIRECT;
      end

      ST_REDIRECT: begin
        busy       = 1'b1;
        target_out = tgt_q;
        flush_if   = 1'b1;
        if (trap_req) begin
          // Trap preempts the pending redirect, which is thrown away.
          trap_ack   = 1'b1;
          trap_latch = 1'b1;
          hold_clear = 1'b1;
          state_d    = ST_FLUSH;
        end else begin
          pc_sel = sel_q;
          pc_we  = imem_ready;
          if (imem_ready) state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Outputs are forced quiet while reset is asserted, independent of inputs.
    if (!rst_n) begin
      pc_sel    = PC_SEL_SEQ;
      pc_we     = 1'b0;
      flush_if  = 1'b0;
      flush_id  = 1'b0;
      mepc_we   = 1'b0;
      mcause_we = 1'b0;
      trap_ack  = 1'b0;
      busy      = 1'b0;
    end
  end

  assign mepc_wdata   = trap_pc_q;
  assign mcause_wdata = trap_cause_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - table-driven scoreboard bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_taken_ex = 1'b0;
  logic [31:0] br_target_ex = '0;
  logic        mret_ex = 1'b0;
  logic        trap_req = 1'b0;
  logic [31:0] trap_pc = '0;
  logic [31:0] trap_cause = '0;
  logic        imem_ready = 1'b0;
  logic [1:0]  pc_sel;
  logic [31:0] target_out;
  logic        pc_we, flush_if, flush_id, mepc_we, mcause_we, trap_ack, busy;
  logic [31:0] mepc_wdata, mcause_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.WIDTH(32), .CAUSE_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .br_taken_ex(br_taken_ex), .br_target_ex(br_target_ex),
    .mret_ex(mret_ex), .trap_req(trap_req), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .imem_ready(imem_ready),
    .pc_sel(pc_sel), .target_out(target_out), .pc_we(pc_we),
    .flush_if(flush_if), .flush_id(flush_id),
    .mepc_we(mepc_we), .mepc_wdata(mepc_wdata),
    .mcause_we(mcause_we), .mcause_wdata(mcause_wdata),
    .trap_ack(trap_ack), .busy(busy)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        br;
    logic [31:0] tgt;
    logic        mret;
    logic        trap;
    logic [31:0] tpc;
    logic [31:0] tcause;
    logic        rdy;
    logic [9:0]  ctl;    // {pc_sel, pc_we, flush_if, flush_id, mepc_we, mcause_we, trap_ack, busy}
    logic        tcare;
    logic [31:0] texp;
    logic        dcare;
    logic [31:0] mepc;
    logic [31:0] mcause;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic logic [9:0] c(logic [1:0] sel, logic we, logic fi, logic fd,
                                   logic mw, logic cw, logic ack, logic bsy);
    return {sel, we, fi, fd, mw, cw, ack, bsy};
  endfunction

  function automatic vec_t mk(string n, logic rst, logic br, logic [31:0] tgt, logic mret,
                              logic trap, logic [31:0] tpc, logic [31:0] tc, logic rdy,
                              logic [9:0] ctl, logic tcare, logic [31:0] texp,
                              logic dcare, logic [31:0] me, logic [31:0] mc);
    vec_t v;
    v.name = n; v.rst = rst; v.br = br; v.tgt = tgt; v.mret = mret; v.trap = trap;
    v.tpc = tpc; v.tcause = tc; v.rdy = rdy; v.ctl = ctl; v.tcare = tcare; v.texp = texp;
    v.dcare = dcare; v.mepc = me; v.mcause = mc;
    return v;
  endfunction

  function automatic logic [9:0] act_ctl();
    return {pc_sel, pc_we, flush_if, flush_id, mepc_we, mcause_we, trap_ack, busy};
  endfunction

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic apply(vec_t v);
    vec_t e;
    @(negedge clk);
    rst_n        = ~v.rst;
    br_taken_ex  = v.br;
    br_target_ex = v.tgt;
    mret_ex      = v.mret;
    trap_req     = v.trap;
    trap_pc      = v.tpc;
    trap_cause   = v.tcause;
    imem_ready   = v.rdy;
    sb.push_back(v);
    #2;
    e = sb.pop_front();
    checks++;
    if (act_ctl() !== e.ctl || (e.tcare && target_out !== e.texp) ||
        (e.dcare && (mepc_wdata !== e.mepc || mcause_wdata !== e.mcause))) begin
      errors++;
      $display("FAIL %s ctl=%b exp_ctl=%b target=%h exp_target=%h mepc=%h exp_mepc=%h mcause=%h exp_mcause=%h",
               e.name, act_ctl(), e.ctl, target_out, e.texp, mepc_wdata, e.mepc,
               mcause_wdata, e.mcause);
    end
  endtask

  localparam logic [9:0] IDLE = 10'b00_1_00_00_0_0;
  localparam logic [9:0] ZERO = 10'b0;

  initial begin
    // reset, idle
    vecs.push_back(mk("reset0",   1,0,0,0,0,0,0,1, ZERO,0,0,0,0,0));
    vecs.push_back(mk("reset1",   1,0,0,0,0,0,0,1, ZERO,0,0,0,0,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk("idle",   0,0,0,0,0,0,0,1, IDLE,0,0,0,0,0));
    // zero-cycle branch
    vecs.push_back(mk("br_fast",  0,1,32'h100,0,0,0,0,1, c(1,1,1,1,0,0,0,0),1,32'h100,0,0,0));
    vecs.push_back(mk("br_after", 0,0,32'h0,0,0,0,0,1, IDLE,1,32'h0,0,0,0));
    // stalled branch, new branch ignored in REDIRECT
    vecs.push_back(mk("br_stall", 0,1,32'h100,0,0,0,0,0, c(1,0,1,1,0,0,0,0),1,32'h100,0,0,0));
    vecs.push_back(mk("redir_w1", 0,0,32'h200,0,0,0,0,0, c(1,0,1,0,0,0,0,1),1,32'h100,0,0,0));
    vecs.push_back(mk("redir_w2", 0,1,32'h200,0,0,0,0,0, c(1,0,1,0,0,0,0,1),1,32'h100,0,0,0));
    vecs.push_back(mk("redir_go", 0,0,32'h200,0,0,0,0,1, c(1,1,1,0,0,0,0,1),1,32'h100,0,0,0));
    vecs.push_back(mk("redir_run",0,0,32'h200,0,0,0,0,1, IDLE,1,32'h200,0,0,0));
    // trap with simultaneous branch; trap_req still held during FLUSH
    vecs.push_back(mk("trap_T",   0,1,32'h300,0,1,32'h40,2,1, c(0,0,0,0,0,0,1,0),0,0,0,0,0));
    vecs.push_back(mk("trap_T1",  0,0,32'h0,0,1,32'h40,2,1, c(0,0,1,1,1,1,0,1),0,0,1,32'h40,2));
    vecs.push_back(mk("trap_T2",  0,0,32'h0,0,0,0,0,1, c(2,1,1,0,0,0,0,1),0,0,0,0,0));
    vecs.push_back(mk("trap_run", 0,0,32'h0,0,0,0,0,1, IDLE,0,0,0,0,0));
    // trap preempts stalled branch
    vecs.push_back(mk("pre_br",   0,1,32'h500,0,0,0,0,0, c(1,0,1,1,0,0,0,0),1,32'h500,0,0,0));
    vecs.push_back(mk("pre_wait", 0,0,32'h0,0,0,0,0,0, c(1,0,1,0,0,0,0,1),1,32'h500,0,0,0));
    vecs.push_back(mk("pre_trap", 0,0,32'h0,0,1,32'h80,7,0, c(0,0,1,0,0,0,1,1),0,0,0,0,0));
    vecs.push_back(mk("pre_flush",0,0,32'h0,0,0,0,0,0, c(0,0,1,1,1,1,0,1),0,0,1,32'h80,7));
    vecs.push_back(mk("pre_w2",   0,1,32'h600,0,0,0,0,0, c(2,0,1,0,0,0,0,1),0,0,0,0,0));
    vecs.push_back(mk("pre_go",   0,0,32'h0,0,0,0,0,1, c(2,1,1,0,0,0,0,1),0,0,0,0,0));
    vecs.push_back(mk("pre_run",  0,0,32'h0,0,0,0,0,1, IDLE,0,0,0,0,0));
    // mret: fast, priority over branch, stalled
    vecs.push_back(mk("mret_fast",0,0,32'h0,1,0,0,0,1, c(3,1,1,1,0,0,0,0),0,0,0,0,0));
    vecs.push_back(mk("mret_pri", 0,1,32'h700,1,0,0,0,1, c(3,1,1,1,0,0,0,0),0,0,0,0,0));
    vecs.push_back(mk("mret_stl", 0,0,32'h0,1,0,0,0,0, c(3,0,1,1,0,0,0,0),0,0,0,0,0));
    vecs.push_back(mk("mret_go",  0,0,32'h0,0,0,0,0,1, c(3,1,1,0,0,0,0,1),0,0,0,0,0));
    vecs.push_back(mk("idle_norq",0,0,32'h0,0,0,0,0,0, ZERO,0,0,0,0,0));
    // reset during FLUSH
    vecs.push_back(mk("rst_T",    0,0,32'h0,0,1,32'h44,3,1, c(0,0,0,0,0,0,1,0),0,0,0,0,0));
    vecs.push_back(mk("rst_flush",1,0,32'h0,0,0,0,0,1, ZERO,0,0,0,0,0));
    vecs.push_back(mk("rst_rel",  0,0,32'h0,0,0,0,0,1, IDLE,0,0,1,32'h0,0));
    vecs.push_back(mk("rst_rel2", 0,0,32'h0,0,0,0,0,1, IDLE,0,0,0,0,0));

    foreach (vecs[i]) apply(vecs[i]);

    // Random-length stall on a held branch; the return to RUN is bounded.
    begin
      int stalls;
      bit done;
      stalls = $urandom_range(1, 5);
      @(negedge clk);
      br_taken_ex = 1; br_target_ex = 32'hABC; imem_ready = 0;
      #2 chk("hs_first_we", {31'b0, pc_we}, 32'd0);
      for (int i = 0; i < stalls; i++) begin
        @(negedge clk);
        br_taken_ex = 0; br_target_ex = $urandom;
        #2 chk("hs_hold_tgt", target_out, 32'hABC);
        chk("hs_hold_we", {31'b0, pc_we}, 32'd0);
      end
      @(negedge clk);
      imem_ready = 1;
      #2 chk("hs_go", {28'b0, pc_sel, pc_we, busy}, {28'b0, 2'd1, 1'b1, 1'b1});
      done = 0;
      for (int i = 0; i < 10 && !done; i++) begin
        @(negedge clk);
        #2 if (!busy) done = 1;
      end
      chk("hs_back_run", {31'b0, done}, 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
